// File: rtl/expr_result_unpacker_pkg.sv
// Shared constants, field layout tables and the field extraction helper
// for the packed 90-bit expression-result bus {y0..y17}.
package expr_res_pkg;

    localparam int Y_W     = 90;
    localparam int OUT_W   = 6;
    localparam int SUM_W   = 10;
    localparam int NFIELDS = 18;
    localparam int IDX_W   = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = 5'd17;

    // Field widths cycle 4,5,6 within each group of three fields.
    localparam logic [2:0] FIELD_W [NFIELDS] = '{
        3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6,
        3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6,
        3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6
    };

    // MSB bit position of each field inside the packed vector.
    localparam logic [6:0] FIELD_MSB [NFIELDS] = '{
        7'd89, 7'd85, 7'd80, 7'd74, 7'd70, 7'd65,
        7'd59, 7'd55, 7'd50, 7'd44, 7'd40, 7'd35,
        7'd29, 7'd25, 7'd20, 7'd14, 7'd10, 7'd5
    };

    // Groups y3-5, y9-11 and y15-17 carry signed results.
    localparam logic FIELD_SIGNED [NFIELDS] = '{
        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1
    };

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Pull field idx out of vec and extend it to OUT_W bits by its signedness.
    // Out-of-range indices yield zero.
    function automatic logic [OUT_W-1:0] field_ext(
        input logic [Y_W-1:0]   vec,
        input logic [IDX_W-1:0] idx
    );
        logic [Y_W-1:0]   shifted;
        logic [OUT_W-1:0] raw;
        logic [OUT_W-1:0] upper;
        logic [OUT_W-1:0] res;
        logic             top;
        int               w;
        int               lsb;
        if (idx < 5'd18) begin
            w       = int'(FIELD_W[idx]);
            lsb     = int'(FIELD_MSB[idx]) - w + 1;
            shifted = vec >> lsb;
            upper   = {OUT_W{1'b1}} << w;
            raw     = shifted[OUT_W-1:0] & ~upper;
            top     = |(raw & (6'd1 << (w - 1)));
            res     = (FIELD_SIGNED[idx] && top) ? (raw | upper) : raw;
        end else begin
            w       = 0;
            lsb     = 0;
            shifted = '0;
            upper   = '0;
            raw     = '0;
            top     = 1'b0;
            res     = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/expr_result_unpacker_if.sv
// Handshake bundle between the packed-vector producer, the unpacker and
// the per-field consumer.
interface expr_result_unpacker_if;
    import expr_res_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [Y_W-1:0]     in_y;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_idx;
    logic [OUT_W-1:0]   out_val;
    logic               out_last;
    logic [SUM_W-1:0]   out_sum;

    modport master (
        output in_valid, in_y, flush, out_ready,
        input  in_ready, out_valid, out_idx, out_val, out_last, out_sum
    );

    modport slave (
        input  in_valid, in_y, flush, out_ready,
        output in_ready, out_valid, out_idx, out_val, out_last, out_sum
    );
endinterface

// File: rtl/expr_field_extract.sv
// Combinational index-to-field mux with per-field extension; also reports
// whether the selected field is signed so callers can widen it further.
module expr_field_extract
    import expr_res_pkg::*;
(
    input  logic [Y_W-1:0]   vec,
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] val,
    output logic             is_signed
);

    // Select the indexed field and extend it.
    always_comb begin
        val = field_ext(vec, idx);
        if (idx < 5'd18) begin
            is_signed = FIELD_SIGNED[idx];
        end else begin
            is_signed = 1'b0;
        end
    end

endmodule

// File: rtl/expr_result_unpacker.sv
// Accepts one packed result vector per handshake and streams its 18 fields
// one per beat with an inclusive signed running sum. The last beat may
// accept the next vector, so back-to-back vectors stream without a bubble.
module expr_result_unpacker
    import expr_res_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    expr_result_unpacker_if.slave bus
);

    state_t             state_r;
    state_t             state_s;
    logic [Y_W-1:0]     hold_r;
    logic [Y_W-1:0]     hold_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_s;
    logic [SUM_W-1:0]   acc_r;
    logic [SUM_W-1:0]   acc_s;
    logic               out_valid_r;
    logic [OUT_W-1:0]   val_s;
    logic               val_signed_s;
    logic [SUM_W-1:0]   val_wide_s;
    logic [SUM_W-1:0]   sum_s;
    logic               is_last_s;
    logic               beat_s;
    logic               ready_s;
    logic               accept_s;

    expr_field_extract u_extract (
        .vec       (hold_r),
        .idx       (idx_r),
        .val       (val_s),
        .is_signed (val_signed_s)
    );

    // Widen the current field by its own signedness and form the inclusive sum.
    always_comb begin
        if (val_signed_s) begin
            val_wide_s = {{(SUM_W-OUT_W){val_s[OUT_W-1]}}, val_s};
        end else begin
            val_wide_s = {{(SUM_W-OUT_W){1'b0}}, val_s};
        end
        sum_s = acc_r + val_wide_s;
    end

    // Beat, last-field and input-ready qualifiers; flush and reset block accepts.
    always_comb begin
        is_last_s = (idx_r == LAST_IDX);
        beat_s    = (state_r == STREAM) && bus.out_ready;
        if (!rst_n || bus.flush) begin
            ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            ready_s = 1'b1;
        end else begin
            ready_s = beat_s && is_last_s;
        end
        accept_s = bus.in_valid && ready_s;
    end

    // Next-state logic: flush wins over any beat or accept in the same cycle.
    always_comb begin
        state_s = state_r;
        hold_s  = hold_r;
        idx_s   = idx_r;
        acc_s   = acc_r;
        if (bus.flush) begin
            state_s = IDLE;
            hold_s  = '0;
            idx_s   = '0;
            acc_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_s = STREAM;
                        hold_s  = bus.in_y;
                        idx_s   = '0;
                        acc_s   = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                STREAM: begin
                    if (beat_s && is_last_s) begin
                        idx_s = '0;
                        acc_s = '0;
                        if (accept_s) begin
                            hold_s = bus.in_y;
                        end else begin
                            state_s = IDLE;
                        end
                    end else if (beat_s) begin
                        idx_s = idx_r + 5'd1;
                        acc_s = sum_s;
                    end else begin
                        state_s = STREAM;
                    end
                end
                default: begin
                    state_s = IDLE;
                    idx_s   = '0;
                    acc_s   = '0;
                end
            endcase
        end
    end

    // State, held vector, index and accumulator registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            hold_r      <= '0;
            idx_r       <= '0;
            acc_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            hold_r      <= hold_s;
            idx_r       <= idx_s;
            acc_r       <= acc_s;
            out_valid_r <= (state_s == STREAM);
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_idx   = idx_r;
    assign bus.out_val   = val_s;
    assign bus.out_last  = is_last_s;
    assign bus.out_sum   = sum_s;

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Directed and randomized checks of expr_result_unpacker against a
// field-arithmetic reference model built from the bus layout rules.
module tb_expr_result_unpacker;

    logic clk = 1'b0;
    logic rst_n;

    expr_result_unpacker_if bus();

    expr_result_unpacker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_busy;
    logic [89:0] m_vec;
    int          m_idx;
    int          m_acc;

    logic [89:0] vq[$];
    int          stall_at;
    int          stall_len;
    int          stall_cnt;
    int          flush_at;
    int          rst_at;
    bit          rnd_rdy;
    int          obs_beats;
    logic [5:0]  obs_val [18];
    logic [9:0]  obs_sum [18];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Field value as a plain integer, computed from the layout rules.
    function automatic int spec_field(input logic [89:0] vec, input int i);
        int w;
        int msb;
        int off;
        int v;
        logic [89:0] t;
        off = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 4 : 9);
        w   = 4 + i % 3;
        msb = 89 - 15 * (i / 3) - off;
        t   = vec >> (msb - w + 1);
        v   = 0;
        for (int k = 0; k < w; k++) begin
            if (t[0]) v += (1 << k);
            t = t >> 1;
        end
        if (((i / 3) % 2) == 1 && v >= (1 << (w - 1))) v -= (1 << w);
        return v;
    endfunction

    task automatic model_load(input logic [89:0] y);
        m_busy = 1'b1;
        m_vec  = y;
        m_idx  = 0;
        m_acc  = 0;
    endtask

    // One clock: drive, check against the model, advance across the edge.
    task automatic cyc(input bit iv, input logic [89:0] y, input bit ordy, input bit fl,
                       output bit took);
        int f;
        bit exp_rdy;
        f = 0;
        took = 1'b0;
        bus.in_valid  = iv;
        bus.in_y      = y;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        if (!rst_n) begin
            chk("ready_in_reset", bus.in_ready, 0);
        end else begin
            exp_rdy = !fl && (!m_busy || (ordy && m_idx == 17));
            chk("out_valid", bus.out_valid, m_busy);
            chk("in_ready", bus.in_ready, exp_rdy);
            if (m_busy) begin
                f = spec_field(m_vec, m_idx);
                chk("out_idx", bus.out_idx, m_idx);
                chk("out_val", bus.out_val, f & 63);
                chk("out_sum", bus.out_sum, (m_acc + f) & 1023);
                chk("out_last", bus.out_last, m_idx == 17);
            end
            if (bus.out_valid && ordy && bus.out_idx < 5'd18) begin
                obs_beats++;
                obs_val[bus.out_idx] = bus.out_val;
                obs_sum[bus.out_idx] = bus.out_sum;
            end
            took = iv && exp_rdy;
        end
        @(posedge clk);
        if (!rst_n || fl) begin
            m_busy = 1'b0;
            m_idx  = 0;
            m_acc  = 0;
        end else if (!m_busy) begin
            if (iv) model_load(y);
        end else if (ordy) begin
            if (m_idx == 17) begin
                if (iv) model_load(y);
                else m_busy = 1'b0;
            end else begin
                m_acc += f;
                m_idx++;
            end
        end
        #1;
    endtask

    // Offer the queued vectors until everything has streamed out.
    task automatic run(input int budget, output int n);
        bit took;
        bit ordy;
        bit fl;
        bit iv;
        n = 0;
        stall_cnt = 0;
        obs_beats = 0;
        for (int i = 0; i < 18; i++) begin
            obs_val[i] = 6'h00;
            obs_sum[i] = 10'h000;
        end
        while ((vq.size() > 0 || m_busy) && n < budget) begin
            ordy = 1'b1;
            fl   = 1'b0;
            if (rnd_rdy) ordy = ($urandom_range(0, 3) != 0);
            if (m_busy && m_idx == stall_at && stall_cnt < stall_len) begin
                ordy = 1'b0;
                stall_cnt++;
            end
            if (m_busy && m_idx == flush_at) begin
                fl = 1'b1;
                flush_at = -1;
            end
            if (m_busy && m_idx == rst_at) begin
                rst_n = 1'b0;
                rst_at = -1;
            end
            iv = (vq.size() > 0) && (!rnd_rdy || $urandom_range(0, 1) == 1);
            cyc(iv, (vq.size() > 0) ? vq[0] : 90'd0, ordy, fl, took);
            rst_n = 1'b1;
            if (took) void'(vq.pop_front());
            n++;
        end
        chk("budget", n < budget, 1);
    endtask

    initial begin
        bit          took;
        int          n;
        logic [95:0] r;

        rst_n = 1'b0;
        m_busy = 1'b0; m_idx = 0; m_acc = 0; m_vec = '0;
        stall_at = -1; stall_len = 0; flush_at = -1; rst_at = -1; rnd_rdy = 1'b0;
        obs_beats = 0;
        #1;

        // reset
        cyc(1'b1, {90{1'b1}}, 1'b1, 1'b0, took);
        cyc(1'b1, {90{1'b1}}, 1'b1, 1'b0, took);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        rst_n = 1'b1;

        // all-zero vector
        vq.push_back(90'd0);
        run(200, n);
        chk("zero_beats", obs_beats, 18);
        chk("zero_cycles", n, 19);
        chk("zero_sum17", obs_sum[17], 10'h000);

        // all-ones vector
        vq.push_back({90{1'b1}});
        run(200, n);
        chk("ones_val0", obs_val[0], 6'h0F);
        chk("ones_val1", obs_val[1], 6'h1F);
        chk("ones_val2", obs_val[2], 6'h3F);
        chk("ones_val3", obs_val[3], 6'h3F);
        chk("ones_sum17", obs_sum[17], 10'h13E);

        // single negative field y3
        vq.push_back(90'd1 << 74);
        run(200, n);
        chk("y3_val", obs_val[3], 6'h38);
        chk("y3_sum3", obs_sum[3], 10'h3F8);
        chk("y3_sum17", obs_sum[17], 10'h3F8);

        // single unsigned field y0
        vq.push_back(90'd1 << 89);
        run(200, n);
        chk("y0_val", obs_val[0], 6'h08);
        chk("y0_sum17", obs_sum[17], 10'h008);

        // back-to-back vectors, no bubble
        r = {$urandom(), $urandom(), $urandom()};
        vq.push_back(r[89:0]);
        vq.push_back({90{1'b1}});
        run(200, n);
        chk("b2b_beats", obs_beats, 36);
        chk("b2b_cycles", n, 37);
        chk("b2b_sum17", obs_sum[17], 10'h13E);

        // backpressure at idx 7
        stall_at = 7; stall_len = 5;
        r = {$urandom(), $urandom(), $urandom()};
        vq.push_back(r[89:0]);
        run(200, n);
        chk("stall_beats", obs_beats, 18);
        chk("stall_cycles", n, 24);
        stall_at = -1;

        // flush at idx 10, then a fresh vector
        flush_at = 10;
        vq.push_back({90{1'b1}});
        vq.push_back(90'd1 << 74);
        run(200, n);
        chk("flush_cycles", n, 31);
        chk("flush_sum17", obs_sum[17], 10'h3F8);

        // reset at idx 10, then a fresh vector
        rst_at = 10;
        vq.push_back({90{1'b1}});
        vq.push_back(90'd1 << 89);
        run(200, n);
        chk("rst_cycles", n, 31);
        chk("rst_sum17", obs_sum[17], 10'h008);

        // randomized vectors with random valid/ready
        rnd_rdy = 1'b1;
        for (int v = 0; v < 8; v++) begin
            r = {$urandom(), $urandom(), $urandom()};
            vq.push_back(r[89:0]);
        end
        run(2000, n);
        rnd_rdy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
